// File: rtl/vx_perf_snapshot_ctrl_if.sv
// vx_perf_snapshot_ctrl_if
//   Counter readout beat stream: one counter per beat, valid/ready handshake.
//   master (controller): out_valid, out_idx, out_data, out_last ; in out_ready
//   slave  (readout)   : the reverse
interface vx_perf_snapshot_ctrl_if #(
  parameter int CTR_W = 44,
  parameter int IDX_W = 3
);
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [CTR_W-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, out_idx, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_idx, out_data, out_last, output out_ready);
endinterface

// File: rtl/vx_perf_snapshot_ctrl.sv
// vx_perf_snapshot_ctrl
//   Captures all NUM_CTRS perf counters on the same clock edge, either on a
//   periodic timer expiry or a manual trigger, then streams them out one
//   counter per beat.
//   Ports:
//     clk, reset_n         clock, async active-low reset
//     cfg_en, cfg_period   periodic sampling enable / period (0 = timer off)
//     trig                 manual one-cycle sample request
//     ctr_in               flattened counters, ctr i at [i*CTR_W +: CTR_W]
//     ob                   beat stream (vx_perf_snapshot_ctrl_if.master)
//     busy                 sample in progress
//     sample_seq           captures taken (wraps)
//     dropped_cnt          requests lost while busy (saturates)
//   Build option: PERF_SNAPSHOT_DELTA_EN -- stream per-sample deltas
//   (ctr - previous capture, mod 2^CTR_W) instead of absolute values.

// Per-counter capture register.
module vx_perf_snapshot_lane #(
  parameter int CTR_W = 44
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cap,
  input  logic [CTR_W-1:0] ctr,
  output logic [CTR_W-1:0] snap
);
`ifdef PERF_SNAPSHOT_DELTA_EN
  logic [CTR_W-1:0] prev;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap <= '0;
      prev <= '0;
    end else if (cap) begin
      snap <= ctr - prev;  // modular subtract handles counter wrap
      prev <= ctr;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  snap <= '0;
    else if (cap)  snap <= ctr;
  end
`endif
endmodule

module vx_perf_snapshot_ctrl #(
  parameter int NUM_CTRS = 8,
  parameter int CTR_W    = 44,
  parameter int PERIOD_W = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_en,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic                      trig,
  input  logic [NUM_CTRS*CTR_W-1:0] ctr_in,
  vx_perf_snapshot_ctrl_if.master   ob,
  output logic                      busy,
  output logic [15:0]               sample_seq,
  output logic [15:0]               dropped_cnt
);
  localparam int IDX_W = $clog2(NUM_CTRS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CTRS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;

  state_t                           state;
  logic [PERIOD_W-1:0]              timer;
  logic                             expiry, req;
  logic [NUM_CTRS-1:0][CTR_W-1:0]   snap;
  logic [IDX_W-1:0]                 idx;
  logic                             valid_q, last_q;

  // >= rather than == so a period shrunk below the running count still fires.
  assign expiry = cfg_en && (cfg_period != '0) && (timer >= cfg_period - PERIOD_W'(1));
  assign req    = trig | expiry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           timer <= '0;
    else if (!cfg_en || cfg_period == '0)   timer <= '0;
    else if (expiry)                        timer <= '0;
    else                                    timer <= timer + PERIOD_W'(1);
  end

  for (genvar g = 0; g < NUM_CTRS; g++) begin : g_lane
    vx_perf_snapshot_lane #(.CTR_W(CTR_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .cap     (state == CAPTURE),
      .ctr     (ctr_in[g*CTR_W +: CTR_W]),
      .snap    (snap[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      idx         <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      sample_seq  <= '0;
      dropped_cnt <= '0;
    end else begin
      // Anything arriving outside IDLE is lost, including the final-beat cycle.
      if (req && state != IDLE && dropped_cnt != 16'hFFFF)
        dropped_cnt <= dropped_cnt + 16'd1;
      case (state)
        IDLE: if (req) begin
          state <= CAPTURE;
          busy  <= 1'b1;
        end
        CAPTURE: begin
          state      <= STREAM;
          sample_seq <= sample_seq + 16'd1;
          idx        <= '0;
          valid_q    <= 1'b1;
          last_q     <= 1'b0;
        end
        STREAM: if (ob.out_ready) begin
          if (idx == LAST_IDX) begin
            state   <= IDLE;
            busy    <= 1'b0;
            idx     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            idx    <= idx + IDX_W'(1);
            last_q <= (idx + IDX_W'(1)) == LAST_IDX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ob.out_valid = valid_q;
  assign ob.out_idx   = idx;
  assign ob.out_last  = last_q;
  assign ob.out_data  = valid_q ? snap[idx] : '0;
endmodule

// File: tb/tb_vx_perf_snapshot_ctrl.sv
module tb_vx_perf_snapshot_ctrl;
  localparam int NC = 8;
  localparam int CW = 44;

  typedef struct {
    logic [2:0]    idx;
    logic [CW-1:0] data;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_en = 1'b0;
  logic [31:0]       cfg_period = '0;
  logic              trig = 1'b0;
  logic [NC*CW-1:0]  ctr_in = '0;
  logic              busy;
  logic [15:0]       sample_seq, dropped_cnt;

  vx_perf_snapshot_ctrl_if #(.CTR_W(CW), .IDX_W(3)) ob ();

  vx_perf_snapshot_ctrl #(.NUM_CTRS(NC), .CTR_W(CW), .PERIOD_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_en      (cfg_en),
    .cfg_period  (cfg_period),
    .trig        (trig),
    .ctr_in      (ctr_in),
    .ob          (ob),
    .busy        (busy),
    .sample_seq  (sample_seq),
    .dropped_cnt (dropped_cnt)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    nbeats = 0;
  int    first_cyc[$];
  beat_t sb_q[$];
  logic  rdy_toggle = 1'b0;
  logic  scramble = 1'b0;
  logic [NC-1:0][CW-1:0] mprev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats for a capture whose sampling edge is the next posedge.
  task automatic push_sample();
    beat_t b;
    for (int i = 0; i < NC; i++) begin
      logic [CW-1:0] v;
      v = ctr_in[i*CW +: CW];
      b.idx  = 3'(i);
      b.last = (i == NC - 1);
`ifdef PERF_SNAPSHOT_DELTA_EN
      b.data   = v - mprev[i];
      mprev[i] = v;
`else
      b.data = v;
`endif
      sb_q.push_back(b);
    end
  endtask

  // Leaves the bench in the CAPTURE cycle (just after the accepting edge).
  task automatic trig_sample();
    trig = 1'b1;
    @(posedge clk); #2;
    trig = 1'b0;
    push_sample();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle timeout", busy, 0);
    chk("queue drained", sb_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    mprev   = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", ob.out_valid, 0);
    chk("rst idx", ob.out_idx, 0);
    chk("rst data", ob.out_data, 0);
    chk("rst last", ob.out_last, 0);
    chk("rst busy", busy, 0);
    chk("rst seq", sample_seq, 0);
    chk("rst dropped", dropped_cnt, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic set_ctrs(input int base);
    for (int i = 0; i < NC; i++) ctr_in[i*CW +: CW] = CW'(base + i);
  endtask

  task automatic monitor();
    logic          hold = 1'b0;
    logic [2:0]    hidx = '0;
    logic [CW-1:0] hdata = '0;
    beat_t         b;
    forever begin
      @(negedge clk);
      if (!reset_n) hold = 1'b0;
      else begin
        if (hold)
          chk("held beat", {ob.out_valid, ob.out_idx, ob.out_data}, {1'b1, hidx, hdata});
        if (ob.out_valid && ob.out_ready) begin
          if (sb_q.size() == 0) chk("unexpected beat", 1, 0);
          else begin
            b = sb_q.pop_front();
            chk("beat", {ob.out_idx, ob.out_last, ob.out_data}, {b.idx, b.last, b.data});
          end
          nbeats++;
          if (ob.out_idx == 3'd0) first_cyc.push_back(cyc);
        end
        hold  = ob.out_valid && !ob.out_ready;
        hidx  = ob.out_idx;
        hdata = ob.out_data;
      end
    end
  endtask

  task automatic background();
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rdy_toggle) ob.out_ready = ~ob.out_ready;
      if (scramble) set_ctrs(cyc * 1000);
    end
  endtask

  initial begin
    int n, b0;
    ob.out_ready = 1'b1;
    fork
      monitor();
      background();
    join_none

    // 1: single manual sample, full throughput
    apply_reset();
    set_ctrs(100);
    trig_sample();
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #2;
    end
    chk("busy cycles", n, 9);
    chk("t1 queue drained", sb_q.size(), 0);
    chk("t1 seq", sample_seq, 1);
    chk("t1 dropped", dropped_cnt, 0);

    // 2: periodic sampling, period 20, 200 cycles
    apply_reset();
    set_ctrs(100);
    for (int s = 0; s < 10; s++) push_sample();
    first_cyc.delete();
    cfg_period = 32'd20;
    cfg_en = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    cfg_en = 1'b0;
    wait_idle(50);
    chk("t2 samples", first_cyc.size(), 10);
    for (int s = 1; s < first_cyc.size(); s++)
      chk("t2 spacing", first_cyc[s] - first_cyc[s-1], 20);
    chk("t2 seq", sample_seq, 10);
    chk("t2 dropped", dropped_cnt, 0);

    // 3: backpressure with counters changing every cycle
    apply_reset();
    rdy_toggle = 1'b1;
    scramble   = 1'b1;
    b0 = nbeats;
    @(posedge clk); #2;
    trig_sample();
    wait_idle(100);
    rdy_toggle = 1'b0;
    scramble   = 1'b0;
    ob.out_ready = 1'b1;
    chk("t3 beats", nbeats - b0, 8);
    chk("t3 seq", sample_seq, 1);

    // 4: requests while busy, then trig+expiry together in IDLE
    apply_reset();
    set_ctrs(200);
    trig_sample();
    repeat (4) @(posedge clk);
    #2;
    chk("t4 at beat3", ob.out_idx, 3);
    trig = 1'b1; @(posedge clk); #2; trig = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t4 at beat7", {ob.out_valid, ob.out_idx}, {1'b1, 3'd7});
    trig = 1'b1; @(posedge clk); #2; trig = 1'b0;
    chk("t4 idle after stream", busy, 0);
    chk("t4 dropped", dropped_cnt, 2);
    chk("t4 queue drained", sb_q.size(), 0);
    @(posedge clk); #2;
    cfg_period = 32'd5;
    cfg_en = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    cfg_en = 1'b1;
    trig = 1'b1; @(posedge clk); #2; trig = 1'b0; cfg_en = 1'b0;
    push_sample();
    wait_idle(50);
    repeat (3) @(posedge clk);
    #2;
    chk("t4 seq", sample_seq, 2);
    chk("t4 dropped final", dropped_cnt, 2);

    // 5: async reset mid-stream
    apply_reset();
    set_ctrs(300);
    trig_sample();
    repeat (5) @(posedge clk);
    #2;
    chk("t5 at beat4", ob.out_idx, 4);
    reset_n = 1'b0;
    #1;
    chk("t5 valid on reset", ob.out_valid, 0);
    chk("t5 busy on reset", busy, 0);
    chk("t5 seq on reset", sample_seq, 0);
    chk("t5 last on reset", ob.out_last, 0);
    sb_q.delete();
    mprev = '0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #2;
    trig_sample();
    wait_idle(50);
    chk("t5 seq", sample_seq, 1);

`ifdef PERF_SNAPSHOT_DELTA_EN
    // 6: delta mode: 50, 80 -> 50, 30 ; 2^44-5, 3 -> 8 on the second pair
    apply_reset();
    set_ctrs(10);
    ctr_in[0 +: CW] = CW'(50);
    trig_sample(); wait_idle(50);
    ctr_in[0 +: CW] = CW'(80);
    trig_sample(); wait_idle(50);
    ctr_in[0 +: CW] = {CW{1'b1}} - CW'(4);
    trig_sample(); wait_idle(50);
    ctr_in[0 +: CW] = CW'(3);
    trig_sample(); wait_idle(50);
    chk("t6 seq", sample_seq, 4);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
